traffic_light_monitor: RTL and testbench

- Passive checker on the opposite side of the traffic-light controller's output interface.
- Samples the south and west lamp buses every clock, decodes the current intersection phase, and measures how long each phase lasts.
- Flags illegal encodings, conflicting greens, out-of-order phases and wrong phase durations.
- Sits beside the controller in the top level; it feeds the status/debug LEDs and the verification bench.

---
 rtl/traffic_light_monitor.sv | 171 +++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic-light controller outputs: decodes the lamp
// buses into a phase, times each phase and reports encoding/order/timing errors.
module traffic_light_monitor #(
    parameter int GREEN_LEN  = 20,
    parameter int YELLOW_LEN = 3,
    parameter int RED1_LEN   = 57,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light_s,
    input  logic [2:0]       light_w,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic             phase_valid,
    output logic [CNT_W-1:0] dur,
    output logic             cycle_done,
    output logic [3:0]       err_flags,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_TRACK = 2'd2
    } state_e;

    localparam logic [2:0]       L_G      = 3'b100;
    localparam logic [2:0]       L_Y      = 3'b010;
    localparam logic [2:0]       L_R      = 3'b001;
    localparam logic [1:0]       PH_WY    = 2'd3;
    localparam logic [CNT_W-1:0] GREEN_C  = CNT_W'(GREEN_LEN);
    localparam logic [CNT_W-1:0] YELLOW_C = CNT_W'(YELLOW_LEN);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] SAT      = '1;

    // The opposing red time is implied by the other road's green+yellow; it is not checked.
    if (RED1_LEN < 0) begin : g_red1_unchecked
    end

    state_e           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] dur_q, dur_d;
    logic             valid_q, valid_d;
    logic             cd_q, cd_d;
    logic [3:0]       flags_q, flags_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s_ok, w_ok, enc, conf, all_red, legal;
    logic [1:0]       in_phase;
    logic             same, succ;
    logic [CNT_W-1:0] req_len, dur_inc, cnt_base;
    logic [3:0]       new_err;

    always_comb begin
        s_ok     = (light_s == L_G) || (light_s == L_Y) || (light_s == L_R);
        w_ok     = (light_w == L_G) || (light_w == L_Y) || (light_w == L_R);
        enc      = !(s_ok && w_ok);
        conf     = s_ok && w_ok && (light_s != L_R) && (light_w != L_R);
        all_red  = (light_s == L_R) && (light_w == L_R);
        legal    = !(enc || conf || all_red);
        in_phase = 2'd0;
        case ({light_s, light_w})
            {L_G, L_R}: in_phase = 2'd0;
            {L_Y, L_R}: in_phase = 2'd1;
            {L_R, L_G}: in_phase = 2'd2;
            {L_R, L_Y}: in_phase = 2'd3;
            default:    in_phase = 2'd0;
        endcase
        same    = (in_phase == phase_q);
        succ    = (in_phase == phase_q + 2'd1);
        req_len = phase_q[0] ? YELLOW_C : GREEN_C;
        dur_inc = (dur_q == SAT) ? dur_q : dur_q + ONE;
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        dur_d   = dur_q;
        cd_d    = 1'b0;
        new_err = {1'b0, all_red, conf, enc};
        if (!legal) begin
            state_d = ST_INIT;
            phase_d = 2'd0;
            dur_d   = '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    state_d = ST_SYNC;
                    phase_d = in_phase;
                    dur_d   = ONE;
                end
                ST_SYNC: begin
                    if (same) begin
                        dur_d = dur_inc;
                    end else begin
                        phase_d = in_phase;
                        dur_d   = ONE;
                        if (succ) state_d = ST_TRACK;
                        else      new_err[2] = 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (same) begin
                        dur_d = dur_inc;
                        // Overlong is reported as the count passes the limit; the exit check then skips it.
                        if (dur_q == req_len) new_err[3] = 1'b1;
                    end else if (succ) begin
                        if (dur_q < req_len) new_err[3] = 1'b1;
                        cd_d    = (phase_q == PH_WY) && (dur_q == req_len);
                        phase_d = in_phase;
                        dur_d   = ONE;
                    end else begin
                        new_err[2] = 1'b1;
                        state_d    = ST_SYNC;
                        phase_d    = in_phase;
                        dur_d      = ONE;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                    phase_d = 2'd0;
                    dur_d   = '0;
                end
            endcase
        end
        valid_d = (state_d != ST_INIT);
    end

    // A clear in the same cycle as a new error restarts the count at one.
    always_comb begin
        pulse_d  = |new_err;
        flags_d  = (clr_err ? 4'b0 : flags_q) | new_err;
        cnt_base = clr_err ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (pulse_d && (cnt_base != SAT)) cnt_d = cnt_base + ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            phase_q <= 2'd0;
            dur_q   <= '0;
            valid_q <= 1'b0;
            cd_q    <= 1'b0;
            flags_q <= 4'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            dur_q   <= dur_d;
            valid_q <= valid_d;
            cd_q    <= cd_d;
            flags_q <= flags_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = valid_q;
    assign dur         = dur_q;
    assign cycle_done  = cd_q;
    assign err_flags   = flags_q;
    assign err_pulse   = pulse_q;
    assign err_cnt     = cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed lamp sequences, a phase/run-length
// model compared every cycle, plus hand-computed spot checks.
module tb_traffic_light_monitor;

    localparam int GL = 20;
    localparam int YL = 3;
    localparam logic [2:0] G = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] ls = G;
    logic [2:0] lw = R;
    logic       clr = 1'b0;
    logic [1:0] phase;
    logic       phase_valid;
    logic [7:0] dur;
    logic       cycle_done;
    logic [3:0] err_flags;
    logic       err_pulse;
    logic [7:0] err_cnt;

    int errors = 0;
    int checks = 0;
    int cd_seen = 0;
    int cd_mark;

    always #5 clk = ~clk;

    traffic_light_monitor #(.GREEN_LEN(GL), .YELLOW_LEN(YL), .RED1_LEN(57), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .light_s(ls), .light_w(lw), .clr_err(clr),
        .phase(phase), .phase_valid(phase_valid), .dur(dur), .cycle_done(cycle_done),
        .err_flags(err_flags), .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit onehot3(input logic [2:0] v);
        return (v == G) || (v == Y) || (v == R);
    endfunction

    // Phase index of a legal lamp pair: SG, SY, WG, WY.
    function automatic int pair(input logic [2:0] s, input logic [2:0] w);
        if (s == R) return (w == G) ? 2 : 3;
        return (s == G) ? 0 : 1;
    endfunction

    // Model: mode 0 = not locked, 1 = phase seen but timing unknown, 2 = timing checked.
    int         req[4] = '{GL, YL, GL, YL};
    int         m_mode = 0, m_phase = 0, m_run = 0, m_cnt = 0, p;
    logic [3:0] m_flags = 4'b0, nf;
    bit         m_pulse = 0, m_cd = 0;
    logic [2:0] s_smp = G, w_smp = R;
    logic       c_smp = 1'b0, r_smp = 1'b0;

    always @(posedge clk) begin
        s_smp <= ls;
        w_smp <= lw;
        c_smp <= clr;
        r_smp <= rst;
        cd_seen <= cd_seen + int'(cycle_done);
    end

    always @(negedge clk) begin
        if (!r_smp) begin
            m_mode = 0; m_phase = 0; m_run = 0; m_cnt = 0;
            m_flags = 4'b0; m_pulse = 0; m_cd = 0;
        end else begin
            nf = 4'b0;
            m_cd = 0;
            if (!onehot3(s_smp) || !onehot3(w_smp)) nf[0] = 1'b1;
            else if (s_smp == R && w_smp == R)       nf[2] = 1'b1;
            else if (s_smp != R && w_smp != R)       nf[1] = 1'b1;
            if (nf != 0) begin
                m_mode = 0; m_phase = 0; m_run = 0;
            end else begin
                p = pair(s_smp, w_smp);
                if (m_mode == 0) begin
                    m_mode = 1; m_phase = p; m_run = 1;
                end else if (p == m_phase) begin
                    m_run++;
                    if (m_mode == 2 && m_run == req[p] + 1) nf[3] = 1'b1;
                end else begin
                    if (p != (m_phase + 1) % 4) begin
                        nf[2] = 1'b1;
                        m_mode = 1;
                    end else begin
                        if (m_mode == 2) begin
                            if (m_run < req[m_phase]) nf[3] = 1'b1;
                            if (m_phase == 3 && m_run == req[3]) m_cd = 1;
                        end
                        m_mode = 2;
                    end
                    m_phase = p;
                    m_run = 1;
                end
            end
            if (c_smp) begin
                m_flags = 4'b0;
                m_cnt = 0;
            end
            m_flags = m_flags | nf;
            m_pulse = (nf != 0);
            if (m_pulse && m_cnt < 255) m_cnt++;
        end
        cmp("phase", phase, m_phase);
        cmp("phase_valid", phase_valid, int'(m_mode != 0));
        cmp("dur", dur, (m_run > 255) ? 255 : m_run);
        cmp("cycle_done", cycle_done, m_cd);
        cmp("err_flags", err_flags, m_flags);
        cmp("err_pulse", err_pulse, m_pulse);
        cmp("err_cnt", err_cnt, m_cnt);
    end

    task automatic drive(input logic [2:0] s, input logic [2:0] w, input int n, input bit c = 0);
        ls = s;
        lw = w;
        clr = c;
        repeat (n) @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        cmp("rst_phase", phase, 0);
        cmp("rst_valid", phase_valid, 0);
        cmp("rst_dur", dur, 0);
        cmp("rst_flags", err_flags, 0);
        cmp("rst_cnt", err_cnt, 0);
        rst = 1'b1;

        // nominal: partial SG, then laps ending on WY
        cd_mark = cd_seen;
        drive(G, R, 5);
        cmp("sync_valid", phase_valid, 1);
        cmp("sync_dur", dur, 5);
        repeat (2) begin
            drive(Y, R, YL);
            drive(R, G, GL);
            cmp("nom_wg_dur", dur, 20);
            drive(R, Y, YL);
            drive(G, R, GL);
        end
        drive(Y, R, YL);
        drive(R, G, GL);
        drive(R, Y, YL);
        cmp("nom_cd_count", cd_seen - cd_mark, 2);
        cmp("nom_flags", err_flags, 0);
        cmp("nom_cnt", err_cnt, 0);
        cmp("nom_wy_dur", dur, 3);

        // short green
        drive(G, R, 19);
        drive(Y, R, 1);
        cmp("short_flags", err_flags, 4'b1000);
        cmp("short_cnt", err_cnt, 1);
        cmp("short_pulse", err_pulse, 1);
        cmp("short_phase", phase, 1);
        cmp("short_dur", dur, 1);
        drive(Y, R, 2);
        cmp("short_pulse_off", err_pulse, 0);
        drive(R, G, GL);
        drive(R, Y, YL);
        drive(G, R, GL - 1);
        drive(G, R, 1, 1);
        cmp("clr_flags", err_flags, 0);
        cmp("clr_cnt", err_cnt, 0);

        // overlong yellow
        drive(Y, R, 3);
        cmp("ovl_before", err_cnt, 0);
        drive(Y, R, 1);
        cmp("ovl_pulse", err_pulse, 1);
        cmp("ovl_flags", err_flags, 4'b1000);
        cmp("ovl_dur", dur, 4);
        drive(Y, R, 2);
        drive(R, G, 1);
        cmp("ovl_exit_cnt", err_cnt, 1);
        cmp("ovl_exit_pulse", err_pulse, 0);
        cmp("ovl_exit_phase", phase, 2);
        drive(R, G, GL - 1);
        drive(R, Y, YL);
        drive(G, R, GL - 1);
        drive(G, R, 1, 1);

        // conflict then encoding error
        drive(G, G, 1);
        cmp("conf_flags", err_flags, 4'b0010);
        cmp("conf_valid", phase_valid, 0);
        drive(3'b110, G, 1);
        cmp("enc_flags", err_flags, 4'b0011);
        cmp("enc_cnt", err_cnt, 2);
        cmp("enc_valid", phase_valid, 0);
        drive(G, R, 5);
        cmp("resync_valid", phase_valid, 1);
        cmp("resync_dur", dur, 5);
        drive(Y, R, YL);
        drive(R, G, GL);
        drive(R, Y, YL);
        drive(G, R, GL - 1);
        drive(G, R, 1, 1);

        // sequence skip SG->WG, then a clean WG->WY->SG
        drive(R, G, 1);
        cmp("skip_flags", err_flags, 4'b0100);
        cmp("skip_cnt", err_cnt, 1);
        cmp("skip_phase", phase, 2);
        drive(R, G, GL - 1);
        drive(R, Y, YL);
        drive(G, R, 5);
        cmp("skip_recover_cnt", err_cnt, 1);

        // clear in the same cycle as a time error (SG only 5 long)
        drive(Y, R, 1, 1);
        cmp("clrhit_flags", err_flags, 4'b1000);
        cmp("clrhit_cnt", err_cnt, 1);
        cmp("clrhit_pulse", err_pulse, 1);

        // saturation of err_cnt and dur
        drive(3'b000, 3'b000, 260);
        cmp("sat_cnt", err_cnt, 255);
        cmp("sat_flags", err_flags, 4'b1001);
        drive(G, R, 300);
        cmp("sat_dur", dur, 255);
        cmp("sat_valid", phase_valid, 1);

        // asynchronous reset mid-phase
        #2 rst = 1'b0;
        #1;
        cmp("arst_valid", phase_valid, 0);
        cmp("arst_dur", dur, 0);
        cmp("arst_flags", err_flags, 0);
        cmp("arst_cnt", err_cnt, 0);
        cmp("arst_phase", phase, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(G, R, 3);
        cmp("post_rst_dur", dur, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
